march_controller: RTL and testbench

Sequences a complete March C- memory self-test over the BIST memory. It drives the memory's address, write-data and read/write strobes directly and checks every read against the expected background. It records pass/fail, the first failing address and element, and a saturating failure count. It is a drop-in replacement sequencer for the simple up/down controller path in the BIST top level.

---
 rtl/bist_pkg.sv | 26 ++
 rtl/march_controller_if.sv | 11 +
 rtl/march_rom.sv | 19 +
 rtl/march_controller.sv | 122 ++++++++++++
 tb/tb_march_controller.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared March C- types, op encoding and element table
// for the BIST sequencer.
package bist_pkg;
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_CHECK, S_DONE} state_e;
    typedef enum logic [1:0] {W0 = 2'b00, W1 = 2'b01, R0 = 2'b10, R1 = 2'b11} op_e;
    typedef enum logic [1:0] {DIR_ANY, DIR_UP, DIR_DOWN} dir_e;
    localparam int N_ELEM = 6;
    typedef struct packed {
        dir_e dir;
        op_e  op0;
        op_e  op1;
        logic two;
    } elem_t;
    // Bit 1 of an op selects read, bit 0 is the background value.
    localparam elem_t MARCH_C [N_ELEM] = '{
        '{DIR_ANY,  W0, W0, 1'b0},
        '{DIR_UP,   R0, W1, 1'b1},
        '{DIR_UP,   R1, W0, 1'b1},
        '{DIR_DOWN, R0, W1, 1'b1},
        '{DIR_DOWN, R1, W0, 1'b1},
        '{DIR_ANY,  R0, R0, 1'b0}
    };
    function automatic logic is_read(op_e op);
        return op[1];
    endfunction
endpackage

// File: rtl/march_controller_if.sv
// march_controller_if: memory-side bus between the BIST sequencer and
// the memory under test.
interface march_controller_if #(parameter int a_width = 4, parameter int width = 4);
    logic [a_width-1:0] mem_addr;
    logic [width-1:0]   mem_wdata;
    logic [width-1:0]   mem_rdata;
    logic               mem_write;
    logic               mem_read;
    modport master (output mem_addr, mem_wdata, mem_write, mem_read, input mem_rdata);
    modport slave  (input mem_addr, mem_wdata, mem_write, mem_read, output mem_rdata);
endinterface

// File: rtl/march_rom.sv
// march_rom: maps (element, op index) to op, direction and last-op flag;
// swapping this block changes the March algorithm.
module march_rom
    import bist_pkg::*;
(
    input  logic [2:0] elem_i,
    input  logic       op_idx_i,
    output op_e        op_o,
    output dir_e       dir_o,
    output logic       last_op_o
);
    elem_t e;
    always_comb begin
        e = (elem_i < 3'(N_ELEM)) ? MARCH_C[elem_i] : MARCH_C[0];
        op_o = op_idx_i ? e.op1 : e.op0;
        dir_o = e.dir;
        last_op_o = op_idx_i | ~e.two;
    end
endmodule

// File: rtl/march_controller.sv
// march_controller: runs March C- over the BIST memory and logs
// pass/fail, first failing address/element and a saturating fail count.
module march_controller
    import bist_pkg::*;
#(
    parameter int a_width   = 4,
    parameter int width     = 4,
    parameter int cnt_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    march_controller_if.master    mem,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [a_width-1:0]    fail_addr,
    output logic [2:0]            fail_element,
    output logic [cnt_width-1:0]  fail_count
);
    state_e               state_q, state_d;
    logic [2:0]           elem_q, elem_d, fail_elem_q, fail_elem_d, nxt_elem;
    logic                 opi_q, opi_d, nxt_idx;
    logic [a_width-1:0]   addr_q, addr_d, fail_addr_q, fail_addr_d;
    logic                 fail_q, fail_d;
    logic [cnt_width-1:0] cnt_q, cnt_d;
    op_e                  cur_op, nxt_op;
    dir_e                 cur_dir, nxt_dir;
    logic                 cur_last, nxt_unused, at_end, last_elem, mis;
    state_e               nxt_state;

    march_rom u_cur (.elem_i(elem_q), .op_idx_i(opi_q), .op_o(cur_op), .dir_o(cur_dir), .last_op_o(cur_last));
    // Looks up whichever op follows the current one: next op in the element,
    // first op at the next address, or first op of the next element.
    march_rom u_nxt (.elem_i(nxt_elem), .op_idx_i(nxt_idx), .op_o(nxt_op), .dir_o(nxt_dir), .last_op_o(nxt_unused));

    assign at_end    = (cur_dir == DIR_DOWN) ? (addr_q == '0) : (addr_q == '1);
    assign last_elem = elem_q == 3'(N_ELEM - 1);
    assign nxt_idx   = ~cur_last;
    assign nxt_elem  = (cur_last && at_end) ? elem_q + 3'd1 : elem_q;
    assign nxt_state = is_read(nxt_op) ? S_READ : S_WRITE;
    assign mis       = (state_q == S_CHECK) && (mem.mem_rdata != {width{cur_op[0]}});

    always_comb begin
        state_d = state_q;
        elem_d = elem_q;
        opi_d = opi_q;
        addr_d = addr_q;
        fail_d = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        cnt_d = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) begin
                state_d = S_WRITE;
                elem_d = '0;
                opi_d = 1'b0;
                addr_d = '0;
                fail_d = 1'b0;
                fail_addr_d = '0;
                fail_elem_d = '0;
                cnt_d = '0;
            end
            S_READ: state_d = S_CHECK;
            S_WRITE, S_CHECK: begin
                if (mis) begin
                    fail_d = 1'b1;
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    fail_addr_d = fail_q ? fail_addr_q : addr_q;
                    fail_elem_d = fail_q ? fail_elem_q : elem_q;
                end
                if (!cur_last) begin
                    opi_d = 1'b1;
                    state_d = nxt_state;
                end else if (at_end && last_elem) begin
                    state_d = S_DONE;
                    addr_d = '0;
                end else begin
                    elem_d = nxt_elem;
                    opi_d = 1'b0;
                    addr_d = at_end ? ((nxt_dir == DIR_DOWN) ? '1 : '0)
                                    : ((cur_dir == DIR_DOWN) ? addr_q - 1'b1 : addr_q + 1'b1);
                    state_d = nxt_state;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            elem_q <= '0;
            opi_q <= 1'b0;
            addr_q <= '0;
            fail_q <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            elem_q <= elem_d;
            opi_q <= opi_d;
            addr_q <= addr_d;
            fail_q <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy          = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_CHECK);
    assign done          = state_q == S_DONE;
    assign mem.mem_write = state_q == S_WRITE;
    assign mem.mem_read  = state_q == S_READ;
    assign mem.mem_addr  = busy ? addr_q : '0;
    assign mem.mem_wdata = (state_q == S_WRITE) ? {width{cur_op[0]}} : '0;
    assign fail          = fail_q;
    assign fail_addr     = fail_addr_q;
    assign fail_element  = fail_elem_q;
    assign fail_count    = cnt_q;
endmodule

// File: tb/tb_march_controller.sv
// tb_march_controller: directed runs of the March C- sequencer against a
// behavioural memory with stuck-at faults and a per-cycle expected-op model.
module tb_march_controller;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    march_controller_if #(.a_width(AW), .width(DW)) bus ();
    march_controller_if #(.a_width(AW), .width(DW)) bus1 ();

    logic          busy, done, fail, busy1, done1, fail1;
    logic [AW-1:0] fail_addr, fail_addr1;
    logic [2:0]    fail_element, fail_element1;
    logic [7:0]    fail_count;
    logic [0:0]    fail_count1;

    march_controller #(.a_width(AW), .width(DW), .cnt_width(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mem(bus), .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_element(fail_element), .fail_count(fail_count));

    // Every word stuck-at-0: reads always return zero.
    march_controller #(.a_width(AW), .width(DW), .cnt_width(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .mem(bus1), .busy(busy1), .done(done1), .fail(fail1),
        .fail_addr(fail_addr1), .fail_element(fail_element1), .fail_count(fail_count1));
    assign bus1.mem_rdata = '0;

    logic [DW-1:0] mem_arr [N];
    logic [DW-1:0] mask [N];
    logic [DW-1:0] rdata_q;
    always @(posedge clk) begin
        if (bus.mem_write) mem_arr[bus.mem_addr] <= bus.mem_wdata & ~mask[bus.mem_addr];
        if (bus.mem_read) rdata_q <= mem_arr[bus.mem_addr] & ~mask[bus.mem_addr];
    end
    assign bus.mem_rdata = rdata_q;

    int errors = 0;
    int checks = 0;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Expected per-cycle activity: 1 write, 2 read, 3 compare cycle.
    int            exp_kind [256];
    logic [AW-1:0] exp_a [256];
    logic [DW-1:0] exp_d [256];
    int            last_c, m_cnt, m_faddr, m_felem;

    task automatic build_model();
        int ops [6][2];
        bit dn [6];
        logic [DW-1:0] mm [N];
        logic [DW-1:0] v;
        int c, a, op;
        ops = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};
        dn = '{0, 0, 0, 1, 1, 0};
        c = 1;
        m_cnt = 0;
        m_faddr = 0;
        m_felem = 0;
        for (int e = 0; e < 6; e++)
            for (int i = 0; i < N; i++) begin
                a = dn[e] ? N - 1 - i : i;
                for (int k = 0; k < 2; k++) begin
                    op = ops[e][k];
                    if (op >= 0) begin
                        v = op[0] ? '1 : '0;
                        if (op < 2) begin
                            exp_kind[c] = 1; exp_a[c] = a[AW-1:0]; exp_d[c] = v;
                            mm[a] = v & ~mask[a];
                            c++;
                        end else begin
                            exp_kind[c] = 2; exp_a[c] = a[AW-1:0];
                            exp_kind[c+1] = 3; exp_a[c+1] = a[AW-1:0];
                            c += 2;
                            if (mm[a] !== v) begin
                                if (m_cnt == 0) begin m_faddr = a; m_felem = e; end
                                m_cnt++;
                            end
                        end
                    end
                end
            end
        last_c = c - 1;
    endtask

    int cyc = 0;
    int t0 = 0;
    bit active = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : compare
        int c;
        if (active) begin
            c = cyc - t0;
            if (c >= 1 && c <= last_c) begin
                chk($sformatf("busy@%0d", c), busy, 1);
                chk($sformatf("done@%0d", c), done, 0);
                chk($sformatf("write@%0d", c), bus.mem_write, exp_kind[c] == 1);
                chk($sformatf("read@%0d", c), bus.mem_read, exp_kind[c] == 2);
                if (exp_kind[c] != 3) chk($sformatf("addr@%0d", c), bus.mem_addr, exp_a[c]);
                if (exp_kind[c] == 1) chk($sformatf("wdata@%0d", c), bus.mem_wdata, exp_d[c]);
            end else if (c == last_c + 1 || c == last_c + 2) begin
                chk($sformatf("busy_end@%0d", c), busy, 0);
                chk($sformatf("done_end@%0d", c), done, 1);
                chk($sformatf("strobes_end@%0d", c), {bus.mem_write, bus.mem_read}, 0);
                chk($sformatf("addr_end@%0d", c), bus.mem_addr, 0);
            end
            if (c == 1) begin
                chk("start_clears_fail", fail, 0);
                chk("start_clears_count", fail_count, 0);
                chk("first_op", {bus.mem_write, bus.mem_addr}, 5'h10);
            end
            if (c == 16) chk("e0_last_addr", {bus.mem_write, bus.mem_addr}, 5'h1f);
            if (c == 113) chk("e3_first_read", {bus.mem_read, bus.mem_addr}, 5'h1f);
            if (c == 114) chk("e3_check_addr", bus.mem_addr, 15);
            if (c == 160) chk("e3_last_write", {bus.mem_write, bus.mem_addr}, 5'h10);
        end
    end

    task automatic run(input int spur1, input int spur2);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        active = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (last_c + 1) begin
            @(negedge clk);
            start = (cyc - t0 == spur1) || (cyc - t0 == spur2);
        end
        @(negedge clk);
        start = 1'b0;
        active = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] acc;
        for (int i = 0; i < N; i++) mask[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy_done_fail", {busy, done, fail}, 0);
        chk("rst_strobes", {bus.mem_write, bus.mem_read}, 0);
        chk("rst_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 0);
        chk("rst_log", {fail_addr, fail_element, fail_count}, 0);
        rst = 1'b1;
        @(negedge clk);

        build_model();
        chk("model_len", last_c, 240);
        chk("model_clean_cnt", m_cnt, 0);
        run(-1, -1);
        chk("clean_fail", fail, 0);
        chk("clean_count", fail_count, 0);
        acc = '0;
        for (int i = 0; i < N; i++) acc |= mem_arr[i];
        chk("clean_mem_zero", acc, 0);
        chk("sat_done", done1, 1);
        chk("sat_count", fail_count1, 1);
        chk("sat_addr", fail_addr1, 0);
        chk("sat_elem", fail_element1, 2);

        mask[5] = 4'b0100;
        build_model();
        chk("model_sa0_cnt", m_cnt, 2);
        chk("model_sa0_addr", m_faddr, 5);
        chk("model_sa0_elem", m_felem, 2);
        run(-1, -1);
        chk("sa0_fail", fail, 1);
        chk("sa0_addr", fail_addr, 5);
        chk("sa0_elem", fail_element, 2);
        chk("sa0_count", fail_count, 2);
        chk("sa0_model_count", fail_count, m_cnt);

        mask[5] = '0;
        build_model();
        run(-1, -1);
        chk("rerun_fail", fail, 0);
        chk("rerun_count", fail_count, 0);

        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        active = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (129) @(negedge clk);
        active = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy_done_fail", {busy, done, fail}, 0);
        chk("midrst_strobes", {bus.mem_write, bus.mem_read}, 0);
        chk("midrst_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 0);
        chk("midrst_log", {fail_addr, fail_element, fail_count}, 0);
        rst = 1'b1;
        @(negedge clk);
        run(10, 100);
        chk("spur_fail", fail, 0);
        chk("spur_done", done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
